// File: rtl/frame_buffer_scheduler.sv
// Frame-buffer ring scheduler: hands writer/reader DRAM base addresses and tracks per-buffer ownership.
// Optional FRAME_STATS_EN adds saturating drop_cnt / repeat_cnt outputs.
module frame_buffer_scheduler #(
  parameter int          NUM_BUFS   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0F80_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0040_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_req,
  output logic        wr_ack,
  output logic        wr_active,
  output logic [31:0] wr_base,
  output logic [2:0]  wr_idx,
  input  logic        wr_done,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic        rd_active,
  output logic [31:0] rd_base,
  output logic [2:0]  rd_idx,
  input  logic        rd_done,
  output logic        rd_empty
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0] drop_cnt,
  output logic [15:0] repeat_cnt
`endif
);

  typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_READING} buf_st_e;

  buf_st_e     st_q [NUM_BUFS];
  buf_st_e     st_d [NUM_BUFS];
  logic        wr_ack_q, wr_active_q, rd_ack_q, rd_active_q, rd_empty_q;
  logic [31:0] wr_base_q, rd_base_q;
  logic [2:0]  wr_idx_q, rd_idx_q;

  logic        ready_any, free_any;
  logic [2:0]  ready_idx, free_idx, wr_pick;
  logic        wr_done_v, rd_done_v, rd_grant, wr_grant, wr_steal, keep_ready;

  function automatic logic [31:0] base_of(input logic [2:0] idx);
    return BASE_ADDR + ({29'd0, idx} * BUF_STRIDE);
  endfunction

  // Descending scan so the lowest FREE index wins.
  always_comb begin
    ready_any = 1'b0;
    ready_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (st_q[i] == B_READY) begin
        ready_any = 1'b1;
        ready_idx = 3'(i);
      end
      if (st_q[i] == B_FREE) begin
        free_any = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  assign wr_done_v  = wr_done & wr_active_q;
  assign rd_done_v  = rd_done & rd_active_q;
  assign rd_grant   = rd_req & ~rd_active_q & ready_any;
  assign wr_grant   = wr_req & ~wr_active_q & (free_any | (ready_any & ~rd_grant));
  assign wr_steal   = wr_grant & ~free_any;
  assign wr_pick    = free_any ? free_idx : ready_idx;
  // The pre-edge READY frame survives this edge unless the reader or a writer steal takes it.
  assign keep_ready = ready_any & ~rd_grant & ~wr_steal;

  always_comb begin
    for (int i = 0; i < NUM_BUFS; i++) begin
      st_d[i] = st_q[i];
      if (rd_grant && ready_idx == 3'(i)) st_d[i] = B_READING;
      if (wr_grant && wr_pick == 3'(i))   st_d[i] = B_WRITING;
      if (wr_done_v) begin
        if (st_q[i] == B_WRITING)                  st_d[i] = B_READY;
        else if (st_q[i] == B_READY && keep_ready) st_d[i] = B_FREE;
      end
      if (rd_done_v && st_q[i] == B_READING)
        st_d[i] = (wr_done_v || keep_ready) ? B_FREE : B_READY;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_BUFS; i++) st_q[i] <= B_FREE;
      wr_ack_q    <= 1'b0;
      wr_active_q <= 1'b0;
      wr_base_q   <= BASE_ADDR;
      wr_idx_q    <= '0;
      rd_ack_q    <= 1'b0;
      rd_active_q <= 1'b0;
      rd_base_q   <= BASE_ADDR;
      rd_idx_q    <= '0;
      rd_empty_q  <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_BUFS; i++) st_q[i] <= st_d[i];
      wr_ack_q <= wr_grant;
      rd_ack_q <= rd_grant;
      if (wr_grant) begin
        wr_active_q <= 1'b1;
        wr_idx_q    <= wr_pick;
        wr_base_q   <= base_of(wr_pick);
      end else if (wr_done_v) begin
        wr_active_q <= 1'b0;
      end
      if (rd_grant) begin
        rd_active_q <= 1'b1;
        rd_idx_q    <= ready_idx;
        rd_base_q   <= base_of(ready_idx);
      end else if (rd_done_v) begin
        rd_active_q <= 1'b0;
      end
      if (wr_done_v) rd_empty_q <= 1'b0;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign wr_active = wr_active_q;
  assign wr_base   = wr_base_q;
  assign wr_idx    = wr_idx_q;
  assign rd_ack    = rd_ack_q;
  assign rd_active = rd_active_q;
  assign rd_base   = rd_base_q;
  assign rd_idx    = rd_idx_q;
  assign rd_empty  = rd_empty_q;

`ifdef FRAME_STATS_EN
  logic [15:0] drop_cnt_q, repeat_cnt_q;
  logic [2:0]  last_rd_idx_q;
  logic        have_last_q, wd_since_q;
  logic        drop_ev, repeat_ev;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign drop_ev   = wr_steal | (wr_done_v & keep_ready);
  // A repeat is a grant of the same index with no frame completed since the previous grant.
  assign repeat_ev = rd_grant & have_last_q & (ready_idx == last_rd_idx_q) & ~wd_since_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drop_cnt_q    <= '0;
      repeat_cnt_q  <= '0;
      last_rd_idx_q <= '0;
      have_last_q   <= 1'b0;
      wd_since_q    <= 1'b0;
    end else begin
      if (drop_ev)   drop_cnt_q   <= sat_inc(drop_cnt_q);
      if (repeat_ev) repeat_cnt_q <= sat_inc(repeat_cnt_q);
      if (rd_grant) begin
        last_rd_idx_q <= ready_idx;
        have_last_q   <= 1'b1;
        wd_since_q    <= wr_done_v;
      end else if (wr_done_v) begin
        wd_since_q    <= 1'b1;
      end
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign repeat_cnt = repeat_cnt_q;
`else
  // Statistics counters are absent in this build.
`endif

endmodule
